// File: rtl/move_legality_responder_pkg.sv
// Shared maze definitions (package maze_pkg): coordinate/address widths,
// playfield bounds, goal cell and the responder state encoding. The move
// controller and renderer import the same constants so everyone agrees on
// where the walls and the exit are.
package maze_pkg;

   localparam int unsigned COORD_W = 3;
   localparam int unsigned ADDR_W  = 6;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [ADDR_W-1:0]  addr_t;

   // Column/row 0 and 7 are border walls.
   localparam coord_t PF_X_MIN = 3'd1;
   localparam coord_t PF_X_MAX = 3'd6;
   localparam coord_t PF_Y_MIN = 3'd1;
   localparam coord_t PF_Y_MAX = 3'd6;
   localparam coord_t PF_GOAL_X = 3'd6;
   localparam coord_t PF_GOAL_Y = 3'd6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      CHECK = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/move_legality_responder_if.sv
// Move-request / move-response handshake between the movement controller
// (master) and the legality responder (slave).
//   req_valid/req_x/req_y/req_ready : proposed cell, valid/ready
//   rsp_valid/rsp_ready             : response, valid/ready
//   rsp_legal/rsp_goal/rsp_x/rsp_y  : verdict and echoed cell
interface move_legality_responder_if;
   import maze_pkg::*;

   logic   req_valid;
   coord_t req_x;
   coord_t req_y;
   logic   req_ready;
   logic   rsp_valid;
   logic   rsp_ready;
   logic   rsp_legal;
   logic   rsp_goal;
   coord_t rsp_x;
   coord_t rsp_y;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_legal, rsp_goal, rsp_x, rsp_y
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_legal, rsp_goal, rsp_x, rsp_y
   );

endinterface

// File: rtl/move_legality_responder_bounds_check.sv
// Combinational playfield bounds test, shared with the move controller's
// pre-check. Unsigned compare: wrapped coordinates (e.g. 0-1 = 7) fail.
//   x, y      : candidate cell
//   in_bounds : 1 when X_MIN<=x<=X_MAX and Y_MIN<=y<=Y_MAX
module bounds_check
   import maze_pkg::*;
#(
   parameter coord_t X_MIN = PF_X_MIN,
   parameter coord_t X_MAX = PF_X_MAX,
   parameter coord_t Y_MIN = PF_Y_MIN,
   parameter coord_t Y_MAX = PF_Y_MAX
) (
   input  coord_t x,
   input  coord_t y,
   output logic   in_bounds
);

   assign in_bounds = (x >= X_MIN) && (x <= X_MAX) &&
                      (y >= Y_MIN) && (y <= Y_MAX);

endmodule

// File: rtl/move_legality_responder.sv
// Move legality responder: accepts a proposed cell, rejects it if outside
// the playfield, otherwise reads its wall bit from the maze-map RAM and
// answers legal/illegal (plus goal hit). Counts delivered illegal
// responses, saturating at 255.
//   clock, resetn          : clock, synchronous active-low reset
//   bus (slave)            : request/response handshake
//   map_addr/map_ren       : RAM address {x,y} and read enable
//   map_rdata              : wall bit, MAP_LATENCY cycles after map_ren
//   illegal_count          : saturating count of illegal responses
module move_legality_responder
   import maze_pkg::*;
#(
   parameter coord_t      X_MIN       = PF_X_MIN,
   parameter coord_t      X_MAX       = PF_X_MAX,
   parameter coord_t      Y_MIN       = PF_Y_MIN,
   parameter coord_t      Y_MAX       = PF_Y_MAX,
   parameter coord_t      GOAL_X      = PF_GOAL_X,
   parameter coord_t      GOAL_Y      = PF_GOAL_Y,
   parameter int unsigned MAP_LATENCY = 1
) (
   input  logic                      clock,
   input  logic                      resetn,
   move_legality_responder_if.slave  bus,
   output addr_t                     map_addr,
   output logic                      map_ren,
   input  logic                      map_rdata,
   output logic [7:0]                illegal_count
);

   // READ lasts MAP_LATENCY cycles: count down from MAP_LATENCY-1 to 0.
   localparam logic [1:0] LAT_LOAD = 2'(MAP_LATENCY - 1);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   coord_t     rsp_x_q, rsp_x_d;
   coord_t     rsp_y_q, rsp_y_d;
   logic       rsp_legal_q, rsp_legal_d;
   logic       rsp_goal_q, rsp_goal_d;
   addr_t      map_addr_q, map_addr_d;
   logic       map_ren_q, map_ren_d;
   logic [7:0] illegal_count_q, illegal_count_d;
   logic       req_in_bounds;

   bounds_check #(
      .X_MIN (X_MIN),
      .X_MAX (X_MAX),
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX)
   ) u_bounds (
      .x         (bus.req_x),
      .y         (bus.req_y),
      .in_bounds (req_in_bounds)
   );

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rsp_x_d         = rsp_x_q;
      rsp_y_d         = rsp_y_q;
      rsp_legal_d     = rsp_legal_q;
      rsp_goal_d      = rsp_goal_q;
      map_addr_d      = map_addr_q;
      map_ren_d       = 1'b0;
      illegal_count_d = illegal_count_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               rsp_x_d     = bus.req_x;
               rsp_y_d     = bus.req_y;
               rsp_legal_d = 1'b0;
               rsp_goal_d  = 1'b0;
               if (req_in_bounds) begin
                  // Registered so map_ren is high only on the first READ cycle.
                  state_d    = READ;
                  cnt_d      = LAT_LOAD;
                  map_addr_d = {bus.req_x, bus.req_y};
                  map_ren_d  = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         READ: begin
            if (cnt_q == '0) state_d = CHECK;
            else             cnt_d   = cnt_q - 2'd1;
         end
         CHECK: begin
            rsp_legal_d = ~map_rdata;
            rsp_goal_d  = ~map_rdata && (rsp_x_q == GOAL_X) && (rsp_y_q == GOAL_Y);
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
               if (!rsp_legal_q && (illegal_count_q != '1))
                  illegal_count_d = illegal_count_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         rsp_x_q         <= '0;
         rsp_y_q         <= '0;
         rsp_legal_q     <= 1'b0;
         rsp_goal_q      <= 1'b0;
         map_addr_q      <= '0;
         map_ren_q       <= 1'b0;
         illegal_count_q <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         rsp_x_q         <= rsp_x_d;
         rsp_y_q         <= rsp_y_d;
         rsp_legal_q     <= rsp_legal_d;
         rsp_goal_q      <= rsp_goal_d;
         map_addr_q      <= map_addr_d;
         map_ren_q       <= map_ren_d;
         illegal_count_q <= illegal_count_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_legal  = rsp_legal_q;
   assign bus.rsp_goal   = rsp_goal_q;
   assign bus.rsp_x      = rsp_x_q;
   assign bus.rsp_y      = rsp_y_q;
   assign map_addr       = map_addr_q;
   assign map_ren        = map_ren_q;
   assign illegal_count  = illegal_count_q;

endmodule

// File: doc/move_legality_responder.md
Name: move_legality_responder

Overview:
- Responder end of the move-request handshake. A movement controller proposes a target cell; this block answers legal/illegal.
- Checks the cell against playfield bounds, then reads the cell's wall bit from the synchronous maze-map RAM.
- Reports a goal hit and keeps a saturating count of rejected moves.
- Sits between the move controller and the maze-map memory.

Parameters:
- X_MIN, 1, lowest legal x (inclusive); column 0 is border wall.
- X_MAX, 6, highest legal x (inclusive).
- Y_MIN, 1, lowest legal y (inclusive).
- Y_MAX, 6, highest legal y (inclusive).
- GOAL_X, 6, x of exit cell.
- GOAL_Y, 6, y of exit cell.
- MAP_LATENCY, 1, map RAM read latency in cycles, range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  move controller presents a proposed cell.
- req_x  in  3  proposed x.
- req_y  in  3  proposed y.
- req_ready  out  1  block idle; can accept a request.
- rsp_valid  out  1  response valid; held until accepted.
- rsp_ready  in  1  controller consumes the response.
- rsp_legal  out  1  1 = move allowed.
- rsp_goal  out  1  1 = legal and cell equals (GOAL_X, GOAL_Y).
- rsp_x  out  3  echoed x of the judged request.
- rsp_y  out  3  echoed y of the judged request.
- map_addr  out  6  RAM address {x,y} (x in [5:3], y in [2:0]).
- map_ren  out  1  RAM read enable.
- map_rdata  in  1  wall bit for map_addr, valid MAP_LATENCY cycles after map_ren; 1 = wall.
- illegal_count  out  8  number of illegal responses delivered, saturating.

Behaviour:
- Reset (clock edge with resetn=0): state IDLE; rsp_valid, rsp_legal, rsp_goal, map_ren = 0; rsp_x, rsp_y, map_addr = 0; illegal_count = 0. Reset mid-transaction aborts it; no response is produced.
- State machine: IDLE, READ, CHECK, RESP.
  - req_ready = 1 only in IDLE.
  - rsp_valid = 1 only in RESP.
- IDLE: on req_valid=1, latch req_x/req_y into rsp_x/rsp_y.
  - If in bounds (X_MIN <= x <= X_MAX and Y_MIN <= y <= Y_MAX): go to READ.
  - Otherwise: go to RESP with rsp_legal=0, rsp_goal=0. No map access.
- READ: lasts exactly MAP_LATENCY cycles, tracked by a 2-bit down-counter loaded at accept.
  - map_addr = {rsp_x, rsp_y}; map_ren = 1 on the first READ cycle only.
  - Then go to CHECK.
- CHECK: one cycle. Sample map_rdata: rsp_legal = ~map_rdata; rsp_goal = ~map_rdata and (rsp_x,rsp_y)==(GOAL_X,GOAL_Y). Go to RESP.
- Latency, counted from the accept edge (cycle 0):
  - in-bounds: rsp_valid first high in cycle MAP_LATENCY+2;
  - out-of-bounds: rsp_valid high in cycle 1.
- RESP: rsp_valid, rsp_legal, rsp_goal, rsp_x, rsp_y held stable until rsp_ready=1.
  - On that edge: go to IDLE, drop rsp_valid.
  - If rsp_legal=0, increment illegal_count unless it is 255 (saturate).
  - A new request is accepted no earlier than the cycle after the handshake (no back-to-back overlap).
- req_valid while not IDLE is ignored and not queued; the requester holds req_valid until req_ready.
- rsp_ready outside RESP is ignored.
- map_addr holds its last value outside READ; map_ren = 0 outside the first READ cycle.
- Bounds compare is unsigned 3-bit. Wrapped coordinates (e.g. x=7 from 0-1) are simply out of bounds.

Decomposition:
- Shared package maze_pkg:
  - state encoding (IDLE=2'd0, READ=2'd1, CHECK=2'd2, RESP=2'd3);
  - playfield bounds and goal constants, so the move controller and the renderer use identical values;
  - COORD_W=3, ADDR_W=6.
- One natural sub-module: bounds_check (combinational; x,y -> in_bounds), reused by the move controller for pre-checks.
- The illegal-move counter stays inline.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles -> req_ready=1, rsp_valid=0, illegal_count=0, map_ren=0.
- Open cell, MAP_LATENCY=1: req (3,4), map_rdata=0, rsp_ready=1 -> map_addr=6'o34 with map_ren in cycle 1; rsp_valid in cycle 3 with rsp_legal=1, rsp_goal=0, rsp_x=3, rsp_y=4; illegal_count stays 0.
- Wall cell plus backpressure: req (2,2), map_rdata=1, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_legal=0 held stable; req_ready=0 throughout; after rsp_ready=1, illegal_count=1.
- Out of bounds: req (0,5) and then req (7,3) -> rsp_valid in cycle 1, rsp_legal=0, map_ren never asserted; illegal_count=2.
- Goal and saturation: req (6,6) open -> rsp_legal=1, rsp_goal=1. Then 260 out-of-bounds requests -> illegal_count=255.
- Reset mid-READ with MAP_LATENCY=3: resetn=0 in cycle 2 -> state IDLE, rsp_valid never asserts, req_ready=1 after reset; next request completes normally.
